// File: rtl/kab_io_pkg.sv
// Shared I/O definitions for the kab serial blocks: FSM state encoding,
// frame-format constants and the baud divisor helper.
package kab_io_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;

  // Clocks per bit, rounded to the nearest integer.
  function automatic int baud_div(input int clk_hz, input int baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/kab_uart_tx_if.sv
// Write-path bus between the I/O register decode and the UART transmitter.
interface kab_uart_tx_if;
  logic       WrEn;
  logic [7:0] WrData;
  logic       Full;
  logic       Busy;
  logic       Overflow;

  modport master (output WrEn, WrData, input  Full, Busy, Overflow);
  modport slave  (input  WrEn, WrData, output Full, Busy, Overflow);
endinterface

// File: rtl/kab_sync_fifo.sv
// Small synchronous FIFO with a registered occupancy count; full/empty are
// decoded from the count so they never depend on the current push/pop.
module kab_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     Clock,
  input  logic                     Reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Storage is only written on an accepted push, so don't-care write data
  // never reaches the array.
  always_ff @(posedge Clock) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

  // Pointers wrap naturally at the power-of-two depth; count tracks occupancy.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/kab_uart_tx.sv
// 8N1 UART transmitter: bytes from the I/O write path are queued in a small
// FIFO and shifted out LSB first on Dout, which idles high.
module kab_uart_tx
  import kab_io_pkg::*;
#(
  parameter int CLK_HZ     = 50000000,
  parameter int BAUD       = 115200,
  parameter int DIV        = baud_div(CLK_HZ, BAUD),
  parameter int FIFO_DEPTH = 4
) (
  input  logic          Clock,
  input  logic          Reset,
  kab_uart_tx_if.slave  bus,
  output logic          Dout
);

  localparam int BW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int CW = $clog2(DATA_BITS);
  localparam logic [BW-1:0] BAUD_LAST = BW'(DIV - 1);
  localparam logic [CW-1:0] DATA_LAST = CW'(DATA_BITS - 1);
  localparam logic [CW-1:0] STOP_LAST = CW'(STOP_BITS - 1);

  tx_state_t                  state;
  logic [BW-1:0]              baud;
  logic [CW-1:0]              bit_cnt;
  logic [7:0]                 shift;
  logic                       dout_q;
  logic                       ovf_q;

  logic                       fifo_full;
  logic                       fifo_empty;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;
  logic [7:0]                 head;
  logic                       pop;
  logic                       baud_end;

  assign baud_end = (baud == BAUD_LAST);

  // Pop whenever the line is free for a new start bit: straight from IDLE,
  // or at the last cycle of the final stop cell for back-to-back frames.
  assign pop = !fifo_empty &&
               ((state == IDLE) ||
                (state == STOP && baud_end && bit_cnt == STOP_LAST));

  kab_sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .Clock (Clock),
    .Reset (Reset),
    .push  (bus.WrEn),
    .wdata (bus.WrData),
    .pop   (pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign bus.Full     = fifo_full;
  assign bus.Busy     = (fifo_count != '0) || (state != IDLE);
  assign bus.Overflow = ovf_q;
  assign Dout         = dout_q;

  // A write that sees the registered full flag is dropped; flag it for one cycle.
  always_ff @(posedge Clock) begin
    if (Reset) ovf_q <= 1'b0;
    else       ovf_q <= bus.WrEn && fifo_full;
  end

  // Frame sequencer: each cell is DIV cycles; Dout is registered so every
  // level change lands exactly on a cell boundary.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state   <= IDLE;
      baud    <= '0;
      bit_cnt <= '0;
      shift   <= '0;
      dout_q  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          baud   <= '0;
          dout_q <= 1'b1;
          if (!fifo_empty) begin
            shift  <= head;
            dout_q <= 1'b0;
            state  <= START;
          end
        end

        START: begin
          if (baud_end) begin
            baud    <= '0;
            bit_cnt <= '0;
            dout_q  <= shift[0];
            state   <= DATA;
          end else begin
            baud <= baud + 1'b1;
          end
        end

        DATA: begin
          if (baud_end) begin
            baud  <= '0;
            shift <= {1'b0, shift[7:1]};
            if (bit_cnt == DATA_LAST) begin
              bit_cnt <= '0;
              dout_q  <= 1'b1;
              state   <= STOP;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              dout_q  <= shift[1];
            end
          end else begin
            baud <= baud + 1'b1;
          end
        end

        STOP: begin
          if (baud_end) begin
            baud <= '0;
            if (bit_cnt != STOP_LAST) begin
              bit_cnt <= bit_cnt + 1'b1;
            end else if (!fifo_empty) begin
              // Next byte already queued: start bit follows with no idle gap.
              bit_cnt <= '0;
              shift   <= head;
              dout_q  <= 1'b0;
              state   <= START;
            end else begin
              bit_cnt <= '0;
              state   <= IDLE;
            end
          end else begin
            baud <= baud + 1'b1;
          end
        end

        default: begin
          state  <= IDLE;
          baud   <= '0;
          dout_q <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_kab_uart_tx.sv
// Directed bench for kab_uart_tx: table of write bursts with expected frames,
// plus hand sequences for reset, mid-frame reset and the STOP-boundary write.
module tb_kab_uart_tx;

  localparam int DIV   = 434;
  localparam int FRAME = 10 * DIV;

  logic Clock = 1'b0;
  logic Reset;
  logic Dout;
  int   cyc = 0;

  kab_uart_tx_if bus ();

  kab_uart_tx dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus),
    .Dout  (Dout)
  );

  always #10 Clock = ~Clock;
  always @(posedge Clock) cyc <= cyc + 1;

  int vectors = 0;
  int errors  = 0;

  typedef struct {
    string            name;
    int               n;
    logic [5:0][7:0]  din;
    int               n_exp;
    logic [5:0][7:0]  dexp;
    int               ovf;
    logic             full;
  } vec_t;

  vec_t tbl [4];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h need %0h", name, got, exp);
    end
  endtask

  // Write n bytes on consecutive cycles starting at the current negedge.
  // k is the posedge at which the first byte is sampled.
  task automatic burst(input int n, input logic [5:0][7:0] d,
                       output int k, output int ovf, output logic full_seen);
    ovf = 0;
    full_seen = 1'b0;
    k = cyc + 1;
    for (int j = 0; j < n; j++) begin
      bus.WrEn   = 1'b1;
      bus.WrData = d[j];
      @(negedge Clock);
      ovf += int'(bus.Overflow);
      if (bus.Full === 1'b1) full_seen = 1'b1;
    end
    bus.WrEn   = 1'b0;
    bus.WrData = 8'hxx;
    repeat (2) begin
      @(negedge Clock);
      ovf += int'(bus.Overflow);
    end
  endtask

  // Wait for a start bit, then check every cycle of the frame against the
  // ideal waveform of exp; returns the cycle of the first start-bit sample.
  task automatic rx_check(input logic [7:0] exp, input string name, input int limit,
                          output int t0);
    int n;
    int bad;
    logic [9:0] bits;
    logic [7:0] got;
    n = 0;
    while (Dout === 1'b1 && n < limit) begin
      @(negedge Clock);
      n++;
    end
    vectors++;
    if (Dout !== 1'b0) begin
      errors++;
      t0 = -1;
      $display("FAIL %s: no start bit within %0d cycles, Dout=%b", name, limit, Dout);
      return;
    end
    t0   = cyc;
    bits = {1'b1, exp, 1'b0};
    bad  = -1;
    got  = '0;
    for (int i = 0; i < FRAME; i++) begin
      if ((i % DIV) == DIV / 2 && (i / DIV) >= 1 && (i / DIV) <= 8)
        got[i / DIV - 1] = Dout;
      if (bad < 0 && (Dout !== bits[i / DIV] || bus.Busy !== 1'b1)) bad = i;
      @(negedge Clock);
    end
    if (bad >= 0) begin
      errors++;
      $display("FAIL %s: frame decoded %02h need %02h, first bad cycle %0d of frame",
               name, got, exp, bad);
    end
  endtask

  int   k, ovf, t0, t1, bad, busy_end;
  int   tf [6];
  logic full_seen;

  initial begin
    tbl[0] = '{name:"single_55",  n:1, din:48'h55,           n_exp:1, dexp:48'h55,           ovf:0, full:1'b0};
    tbl[1] = '{name:"b2b_a5_3c",  n:2, din:48'h3CA5,         n_exp:2, dexp:48'h3CA5,         ovf:0, full:1'b0};
    tbl[2] = '{name:"overflow",   n:6, din:48'h060504030201, n_exp:5, dexp:48'h0504030201,   ovf:1, full:1'b1};
    tbl[3] = '{name:"single_00",  n:1, din:48'h00,           n_exp:1, dexp:48'h00,           ovf:0, full:1'b0};

    Reset      = 1'b1;
    bus.WrEn   = 1'b0;
    bus.WrData = 8'hxx;
    repeat (3) @(negedge Clock);
    chk("reset_dout",     Dout,         1);
    chk("reset_busy",     bus.Busy,     0);
    chk("reset_full",     bus.Full,     0);
    chk("reset_overflow", bus.Overflow, 0);
    Reset = 1'b0;

    bad = 0;
    repeat (1000) begin
      @(negedge Clock);
      if (Dout !== 1'b1 || bus.Busy !== 1'b0 || bus.Full !== 1'b0 || bus.Overflow !== 1'b0)
        bad++;
    end
    chk("idle_quiet_cycles_bad", bad, 0);

    for (int v = 0; v < 4; v++) begin
      fork
        burst(tbl[v].n, tbl[v].din, k, ovf, full_seen);
        begin
          for (int f = 0; f < tbl[v].n_exp; f++)
            rx_check(tbl[v].dexp[f], $sformatf("%s_f%0d", tbl[v].name, f), 2 * FRAME, tf[f]);
          busy_end = int'(bus.Busy);
        end
      join
      chk($sformatf("%s_latency", tbl[v].name), tf[0], k + 1);
      for (int f = 1; f < tbl[v].n_exp; f++)
        chk($sformatf("%s_gap%0d", tbl[v].name, f), tf[f] - tf[f-1], FRAME);
      chk($sformatf("%s_ovf_cycles", tbl[v].name), ovf, tbl[v].ovf);
      chk($sformatf("%s_full_seen", tbl[v].name), full_seen, tbl[v].full);
      chk($sformatf("%s_busy_end", tbl[v].name), busy_end, 0);
      repeat (5) @(negedge Clock);
    end

    // Reset 2000 cycles into the first of two queued frames.
    burst(2, 48'h00FF, k, ovf, full_seen);
    while (cyc < k + 1 + 2000) @(negedge Clock);
    chk("midrst_in_frame_busy", bus.Busy, 1);
    Reset = 1'b1;
    @(negedge Clock);
    chk("midrst_dout", Dout,     1);
    chk("midrst_busy", bus.Busy, 0);
    chk("midrst_full", bus.Full, 0);
    Reset = 1'b0;
    bad = 0;
    repeat (2 * FRAME) begin
      @(negedge Clock);
      if (Dout !== 1'b1 || bus.Busy !== 1'b0) bad++;
    end
    chk("midrst_no_frames_bad", bad, 0);
    fork
      burst(1, 48'h81, k, ovf, full_seen);
      rx_check(8'h81, "after_rst_81", 2 * FRAME, t0);
    join
    chk("after_rst_latency", t0, k + 1);

    // Write landing on the final STOP cycle of the previous frame.
    repeat (5) @(negedge Clock);
    k = cyc + 1;
    fork
      begin
        burst(1, 48'h0F, k, ovf, full_seen);
        while (cyc != k + FRAME) @(negedge Clock);
        bus.WrEn   = 1'b1;
        bus.WrData = 8'h42;
        @(negedge Clock);
        bus.WrEn   = 1'b0;
        bus.WrData = 8'hxx;
      end
      begin
        rx_check(8'h0F, "stopb_first_0f", 2 * FRAME, t0);
        rx_check(8'h42, "stopb_42", 2 * FRAME, t1);
      end
    join
    chk("stopb_first_latency", t0, k + 1);
    chk("stopb_gap_in_range", (t1 - t0 >= FRAME) && (t1 - t0 <= FRAME + 1), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
